instruction_fetch_buffer: RTL and testbench



---
 rtl/pipeline_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/instruction_fetch_buffer.sv | 81 ++++++++
 tb/tb_instruction_fetch_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the sizing helper used by the fetch front end.
package pipeline_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head; flush empties it in one cycle.
module sync_fifo
  import pipeline_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Prefetching instruction fetch front end: credit-limited sequential reads into
// a show-ahead FIFO, with redirect flushing both buffered and in-flight data.
module instruction_fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_next,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               instr_valid,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      count;
  logic [CW:0]        credit_used;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [INSTR_W-1:0] fifo_head;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (imem_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (fifo_head)
  );

  // Buffered plus in-flight words may never exceed the FIFO depth.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = rst_n && !redirect && !fifo_full && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign fifo_push = imem_rvalid && (drop_cnt == '0) && !redirect;
  assign fifo_pop  = fetch_next && !fifo_empty && !redirect;

  assign instr_valid     = !fifo_empty;
  assign instruction_out = fifo_empty ? NOP : fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc    <= redirect_pc;
      outstanding <= outstanding - CW'(imem_rvalid);
      drop_cnt    <= outstanding - CW'(imem_rvalid);
    end else begin
      if (imem_req) fetch_pc <= fetch_pc + 1'b1;
      outstanding <= outstanding + CW'(imem_req) - CW'(imem_rvalid);
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench: directed vector table, directed corner sequences and a
// randomized run against a queue-based reference model with stale tagging.
module tb_instruction_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h0000;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_next;
  logic [15:0] instruction_out;
  logic        instr_valid;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  instruction_fetch_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (16),
    .RESET_PC (RPC),
    .NOP      (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_next      (fetch_next),
    .instruction_out (instruction_out),
    .instr_valid     (instr_valid),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Memory: in-order responses, each no earlier than its latency after issue.
  typedef struct packed {
    logic [15:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t       mem_q[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;

  // Reference model: buffered words and in-flight reads tagged stale/live.
  logic [15:0] mq[$];
  bit          infl[$];
  logic [15:0] mpc;

  logic        s_req;
  logic        s_valid;
  logic [15:0] s_addr;
  logic [15:0] s_out;

  task automatic model_reset();
    mq.delete();
    infl.delete();
    mpc = RPC;
    mem_q.delete();
  endtask

  task automatic step(input logic fn, input logic rd, input logic [15:0] rpc);
    bit          m_valid;
    bit          m_req;
    bit          had;
    bit          stale;
    int unsigned d;
    fetch_next  = fn;
    redirect    = rd;
    redirect_pc = rpc;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr + 16'h1000;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_out   = instruction_out;

    m_valid = (mq.size() != 0);
    m_req   = rst_n && !rd && ((mq.size() + infl.size()) < DEPTH);
    chk("valid", s_valid, m_valid);
    if (m_valid) chk("instr", s_out, mq[0]);
    else         chk("nop", s_out, NOP);
    chk("req", s_req, m_req);
    if (m_req) chk("addr", s_addr, mpc);

    if (rst_n && imem_req) begin
      d = cyc + mem_lat;
      if (mem_q.size() > 0 && d <= mem_q[$].due) d = mem_q[$].due + 1;
      mem_q.push_back('{addr: imem_addr, due: d});
    end

    if (!rst_n) begin
      model_reset();
    end else if (rd) begin
      mq.delete();
      if (imem_rvalid && infl.size() > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i] = 1'b1;
      mpc = rpc;
    end else begin
      had = (mq.size() != 0);
      if (fn && had) void'(mq.pop_front());
      if (imem_rvalid && infl.size() > 0) begin
        stale = infl.pop_front();
        if (!stale) mq.push_back(imem_rdata);
      end
      if (m_req) begin
        infl.push_back(1'b0);
        mpc = mpc + 16'h1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fetch_next  = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("reset_req", imem_req, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    rst_n = 1'b1;
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_nop", instruction_out, NOP);
  endtask

  typedef struct packed {
    logic        fn;
    logic        rv;
    logic [15:0] rd;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] out;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    logic [15:0] exp;
    logic        r_fn;
    logic        r_rd;
    logic [15:0] r_pc;

    // Stall with 1-cycle memory: four reads fill the FIFO, head holds 1000.
    //           fn    rv    rdata     req   addr      valid out
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h1000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h1001, 1'b1, 16'h0002, 1'b1, 16'h1000};
    tbl[3]  = '{1'b0, 1'b1, 16'h1002, 1'b1, 16'h0003, 1'b1, 16'h1000};
    tbl[4]  = '{1'b0, 1'b1, 16'h1003, 1'b0, 16'h0004, 1'b1, 16'h1000};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1000};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1000};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1000};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1000};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1001};
    tbl[10] = '{1'b0, 1'b1, 16'h1004, 1'b0, 16'h0005, 1'b1, 16'h1001};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h1001};

    rst_n       = 1'b0;
    fetch_next  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", instr_valid, 1'b0);
    chk("init_nop", instruction_out, NOP);
    chk("init_req", imem_req, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      fetch_next  = tbl[i].fn;
      redirect    = 1'b0;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_out", i), instruction_out, tbl[i].out);
      @(posedge clk);
      #1;
    end

    // Streaming with fetch_next held high: no gaps once filled.
    do_reset();
    mem_lat = 1;
    exp = 16'h1000;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 16'h0);
      if (i == 0) begin
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, 16'h0000);
      end
      if (i >= 2) begin
        chk("stream_valid", s_valid, 1'b1);
        chk("stream_instr", s_out, exp);
        exp = exp + 16'h1;
      end
    end

    // Redirect together with pop and a returning response.
    step(1'b1, 1'b1, 16'h0100);
    step(1'b0, 1'b0, 16'h0);
    chk("rdp_valid0", s_valid, 1'b0);
    chk("rdp_nop", s_out, NOP);
    chk("rdp_req", s_req, 1'b1);
    chk("rdp_addr", s_addr, 16'h0100);
    step(1'b0, 1'b0, 16'h0);
    chk("rdp_valid1", s_valid, 1'b0);
    step(1'b0, 1'b0, 16'h0);
    chk("rdp_valid2", s_valid, 1'b1);
    chk("rdp_instr", s_out, 16'h1100);

    // Latency 3: redirect with three reads in flight drops all stale data.
    do_reset();
    mem_lat = 3;
    repeat (3) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 16'h0);
      if (s_valid) begin
        found = 1'b1;
        chk("lat3_first", s_out, 16'h1040);
      end
    end
    if (!found) fail("lat3_timeout");

    // Address wrap at the top of the space.
    do_reset();
    mem_lat = 1;
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    chk("wrap_req0", s_req, 1'b1);
    chk("wrap_addr0", s_addr, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    chk("wrap_req1", s_req, 1'b1);
    chk("wrap_addr1", s_addr, 16'h0000);

    // Reset with a full FIFO.
    do_reset();
    mem_lat = 1;
    repeat (8) step(1'b0, 1'b0, 16'h0);
    chk("full_valid", s_valid, 1'b1);
    chk("full_noreq", s_req, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 16'h0);
    chk("midrst_req", s_req, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    chk("postrst_valid", s_valid, 1'b0);
    chk("postrst_req", s_req, 1'b1);
    chk("postrst_addr", s_addr, RPC);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 4);
      r_fn = ($urandom_range(0, 3) != 0);
      r_rd = ($urandom_range(0, 15) == 0);
      r_pc = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(16'hFFFD + $urandom_range(0, 3));
      rst_n = ($urandom_range(0, 199) != 0);
      step(r_fn, r_rd, r_pc);
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
